gpio_in_conditioner: RTL and testbench

//  Front-end for the AHB GPIO input path: synchronises 16 asynchronous pad inputs, debounces them as one word
//  and generates the parity bit, driving the GPIO peripheral's 17-bit GPIOIN bus (MSB = parity).
//  The parity it emits is parity-correct for the GPIO's checker for the current PARITYSEL, so PARITYERR stays 0
//  on clean data.

---
 rtl/gpio_pkg.sv | 19 +
 rtl/gpio_sync_chain.sv | 35 +++
 rtl/gpio_in_conditioner.sv | 115 +++++++++++
 tb/tb_gpio_in_conditioner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO types and helpers for the input conditioner and the GPIO output path.
package gpio_pkg;

    localparam int GPIO_WIDTH = 16;

    typedef logic [GPIO_WIDTH-1:0] gpio_word_t;

    // Whole-word debounce FSM states.
    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } dbnc_state_t;

    // Parity bit that makes the GPIO checker happy: sel=1 odd, sel=0 even.
    function automatic logic gpio_parity(input gpio_word_t word, input logic sel);
        return (^word) ^ sel;
    endfunction

endpackage

// File: rtl/gpio_sync_chain.sv
// Multi-bit flop synchroniser: SYNC_STAGES plain flops per bit, no logic
// between stages, asynchronous active-low reset to 0.
module gpio_sync_chain #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d;

    // Each stage simply takes the previous one; stage 0 takes the raw pads.
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input front-end: synchronise pads, debounce the whole word, and emit
// GPIOIN = {parity, word} ready for the GPIO's parity checker.
// Optional build macro GPIO_PARITY_FAULT_EN adds FAULT_INJ, which inverts the
// parity bit loaded on that edge so the downstream checker flags an error.
module gpio_in_conditioner
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [WIDTH-1:0] PADIN,
    input  logic             PARITYSEL,
    output logic [WIDTH:0]   GPIOIN,
    output logic             CHANGE,
    output logic             SETTLING
`ifdef GPIO_PARITY_FAULT_EN
    ,
    input  logic             FAULT_INJ
`endif
);

    // Counter value on which the candidate has been seen DEBOUNCE_CYCLES times.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_w;

    dbnc_state_t      state_q,  state_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] cand_q,   cand_d;
    logic [7:0]       cnt_q,    cnt_d;
    logic             change_q, change_d;
    logic             par_q,    par_d;

    gpio_sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .din   (PADIN),
        .dout  (sync_w)
    );

    // Debounce next-state, word load and parity of the word that will be held.
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        change_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_w != stable_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        stable_d = sync_w;
                        change_d = 1'b1;
                    end else begin
                        cand_d  = sync_w;
                        cnt_d   = 8'd1;
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (sync_w == stable_q) begin
                    // Glitch: input went back to the accepted word.
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (sync_w != cand_q) begin
                    cand_d = sync_w;
                    cnt_d  = 8'd1;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = cand_q;
                    change_d = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Parity follows stable_d so it lands on the same edge as the data.
        par_d = gpio_parity(stable_d, PARITYSEL);
`ifdef GPIO_PARITY_FAULT_EN
        par_d = par_d ^ FAULT_INJ;
`endif
    end

    // State, word, counter, strobe and parity registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            stable_q <= '0;
            cand_q   <= '0;
            cnt_q    <= 8'd0;
            change_q <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            change_q <= change_d;
            par_q    <= par_d;
        end
    end

    assign GPIOIN   = {par_q, stable_q};
    assign CHANGE   = change_q;
    assign SETTLING = (state_q == SETTLE);

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner. Expected words and the edge on which
// they must appear are queued at stimulus time; a negedge monitor pops one per
// CHANGE strobe.
module tb_gpio_in_conditioner;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [15:0] PADIN;
    logic        PARITYSEL;
    logic [16:0] GPIOIN;
    logic        CHANGE;
    logic        SETTLING;
`ifdef GPIO_PARITY_FAULT_EN
    logic        FAULT_INJ;
`endif

    typedef struct {
        logic [16:0] word;
        int          at_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    gpio_in_conditioner dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .PADIN     (PADIN),
        .PARITYSEL (PARITYSEL),
        .GPIOIN    (GPIOIN),
        .CHANGE    (CHANGE),
        .SETTLING  (SETTLING)
`ifdef GPIO_PARITY_FAULT_EN
        ,
        .FAULT_INJ (FAULT_INJ)
`endif
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance n rising edges, then step 1 time unit past the edge.
    task automatic edges(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Set the pad word now (just after an edge) and expect it on GPIOIN on
    // the edge SYNC_STAGES+DEBOUNCE_CYCLES-1 = 5 edges after it is first sampled.
    task automatic drive_expect(input logic [15:0] pad, input logic [16:0] word);
        exp_t e;
        PADIN    = pad;
        e.word   = word;
        e.at_cyc = cyc + 6;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every CHANGE must match the oldest queued word/edge.
    always @(negedge HCLK) begin
        if (HRESETn === 1'b1 && CHANGE === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_change", {15'd0, GPIOIN}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_word", {15'd0, GPIOIN}, {15'd0, e.word});
                check("sb_cycle", cyc, e.at_cyc);
            end
        end
    end

    initial begin
        int bad;
        int seen;
        HRESETn   = 1'b0;
        PADIN     = 16'h0000;
        PARITYSEL = 1'b0;
`ifdef GPIO_PARITY_FAULT_EN
        FAULT_INJ = 1'b0;
`endif
        // 1. reset state and idle with zero pads
        #2;
        check("rst_gpioin", {15'd0, GPIOIN}, 32'h0);
        check("rst_change", {31'd0, CHANGE}, 32'h0);
        check("rst_settling", {31'd0, SETTLING}, 32'h0);
        edges(2);
        HRESETn = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            edges(1);
            if (GPIOIN !== 17'h0 || SETTLING !== 1'b0 || CHANGE !== 1'b0) bad++;
        end
        check("idle_20_cycles_bad", bad, 0);

        // 2. single bit rise: old value after 5 edges, new after the 6th
        drive_expect(16'h0001, 17'h10001);
        edges(5);
        check("lat_before", {15'd0, GPIOIN}, 32'h0);
        edges(1);
        check("lat_after", {15'd0, GPIOIN}, 32'h10001);

        // back to zero for the glitch test
        drive_expect(16'h0000, 17'h00000);
        edges(8);
        check("back_to_zero", {15'd0, GPIOIN}, 32'h0);

        // 3. 2-cycle glitch: SETTLING pulses, word untouched
        PADIN = 16'h00FF;
        edges(2);
        PADIN = 16'h0000;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (SETTLING === 1'b1) seen = 1;
            edges(1);
        end
        check("glitch_settling_seen", seen, 1);
        check("glitch_settling_end", {31'd0, SETTLING}, 32'h0);
        check("glitch_gpioin", {15'd0, GPIOIN}, 32'h0);

        // candidate restart: 0x0010 for 2 cycles then 0x0020 held
        PADIN = 16'h0010;
        edges(2);
        drive_expect(16'h0020, 17'h10020);
        edges(5);
        check("restart_before", {15'd0, GPIOIN}, 32'h0);
        edges(1);
        check("restart_after", {15'd0, GPIOIN}, 32'h10020);

        // 4. PARITYSEL toggle on a stable 0x00A5 (4 ones, even)
        drive_expect(16'h00A5, 17'h000A5);
        edges(8);
        check("a5_even", {15'd0, GPIOIN}, 32'h000A5);
        PARITYSEL = 1'b1;
        #1;
        check("psel_not_yet", {31'd0, GPIOIN[16]}, 32'h0);
        edges(1);
        check("psel_odd", {15'd0, GPIOIN}, 32'h100A5);
        check("psel_no_change", {31'd0, CHANGE}, 32'h0);
        check("psel_parityerr", {31'd0, (^GPIOIN[15:0]) ^ PARITYSEL ^ GPIOIN[16]}, 32'h0);

        // 5. async reset in the middle of settling toward 0xFFFF
        PADIN = 16'hFFFF;
        edges(3);
        check("mid_settle", {31'd0, SETTLING}, 32'h1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("async_gpioin", {15'd0, GPIOIN}, 32'h0);
        check("async_settling", {31'd0, SETTLING}, 32'h0);
        check("async_change", {31'd0, CHANGE}, 32'h0);
        edges(1);
        HRESETn = 1'b1;
        // 16 ones with odd select -> parity 1
        drive_expect(16'hFFFF, 17'h1FFFF);
        edges(5);
        check("rerun_before", {16'd0, GPIOIN[15:0]}, 32'h0);
        edges(1);
        check("rerun_after", {15'd0, GPIOIN}, 32'h1FFFF);

`ifdef GPIO_PARITY_FAULT_EN
        // 6. one-cycle parity fault on 0x0003 with even select
        PARITYSEL = 1'b0;
        drive_expect(16'h0003, 17'h00003);
        edges(8);
        check("fi_clean", {15'd0, GPIOIN}, 32'h00003);
        FAULT_INJ = 1'b1;
        edges(1);
        FAULT_INJ = 1'b0;
        check("fi_bad_parity", {15'd0, GPIOIN}, 32'h10003);
        check("fi_parityerr", {31'd0, (^GPIOIN[15:0]) ^ PARITYSEL ^ GPIOIN[16]}, 32'h1);
        edges(1);
        check("fi_recovered", {15'd0, GPIOIN}, 32'h00003);
`endif

        edges(10);
        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
